// File: rtl/codemem_loader_ctrl_if.sv
// Bundle of signals between the codemem loader controller, the instruction
// stream source, the filter CPU fetch port and the codemem RAM ports.
interface codemem_loader_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
);
    logic                  cfg_start;
    logic                  cpu_busy;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic                  cpu_rd_en;
    logic [ADDR_WIDTH-1:0] cpu_rd_addr;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  prog_valid;
    logic [ADDR_WIDTH:0]   prog_len;
    logic                  load_err;
    logic                  rd_oob;

    modport master (
        output cfg_start, cpu_busy, in_data, in_valid, in_last, cpu_rd_en, cpu_rd_addr,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        input  prog_valid, prog_len, load_err, rd_oob
    );

    modport slave (
        input  cfg_start, cpu_busy, in_data, in_valid, in_last, cpu_rd_en, cpu_rd_addr,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        output prog_valid, prog_len, load_err, rd_oob
    );
endinterface

// File: rtl/codemem_loader_ctrl.sv
// Owns the codemem write/read ports: loads a program from a valid/ready stream,
// defers reloads while the CPU is busy, and only lets fetches through once loaded.
module codemem_loader_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    codemem_loader_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READY = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   prog_len_q;
    logic                  load_err_q;
    logic                  rd_oob_q;
    logic                  beat_s;
    logic                  last_slot_s;
    logic                  rd_oob_d;

    // A restart in the same cycle as a beat wins, so that beat is dropped.
    assign beat_s      = (state_q == ST_LOAD) & bus.in_valid & ~bus.cfg_start;
    assign last_slot_s = (wr_ptr_q == {ADDR_WIDTH{1'b1}});
    assign rd_oob_d    = (state_q == ST_READY) & bus.cpu_rd_en &
                         ({1'b0, bus.cpu_rd_addr} >= prog_len_q);

    assign bus.prog_len = prog_len_q;
    assign bus.load_err = load_err_q;
    assign bus.rd_oob   = rd_oob_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.cfg_start) begin
            state_d = bus.cpu_busy ? ST_WAIT : ST_LOAD;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (!bus.cpu_busy) state_d = ST_LOAD;
                    else               state_d = ST_WAIT;
                end
                ST_LOAD: begin
                    if (beat_s && bus.in_last)  state_d = ST_READY;
                    else if (beat_s && last_slot_s) state_d = ST_ERR;
                    else                        state_d = ST_LOAD;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output decode: write port only on LOAD beats, read port only in READY
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = {ADDR_WIDTH{1'b0}};
        bus.mem_wr_data = {DATA_WIDTH{1'b0}};
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = {ADDR_WIDTH{1'b0}};
        bus.prog_valid  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (beat_s) begin
                    bus.mem_wr_en   = 1'b1;
                    bus.mem_wr_addr = wr_ptr_q;
                    bus.mem_wr_data = bus.in_data;
                end else begin
                    bus.mem_wr_en   = 1'b0;
                end
            end
            ST_READY: begin
                bus.prog_valid = 1'b1;
                if (bus.cpu_rd_en) begin
                    bus.mem_rd_en   = 1'b1;
                    bus.mem_rd_addr = bus.cpu_rd_addr;
                end else begin
                    bus.mem_rd_en   = 1'b0;
                end
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Write pointer, program length and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
            prog_len_q <= {(ADDR_WIDTH+1){1'b0}};
            load_err_q <= 1'b0;
        end else if (bus.cfg_start) begin
            wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
            load_err_q <= 1'b0;
        end else if (beat_s) begin
            wr_ptr_q <= wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (bus.in_last) begin
                prog_len_q <= {1'b0, wr_ptr_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end else if (last_slot_s) begin
                load_err_q <= 1'b1;
            end
        end
    end

    // Out-of-range flag lines up with the read data, one cycle after the fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_oob_q <= 1'b0;
        end else begin
            rd_oob_q <= rd_oob_d;
        end
    end
endmodule

// File: tb/tb_codemem_loader_ctrl.sv
// Directed bench for codemem_loader_ctrl: per-cycle vector table plus
// hand-written overflow and mid-load reset sequences.
module tb_codemem_loader_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int cs; int bz; int iv; int il; int id; int re; int ra;
        int e_rdy; int e_wen; int e_wa; int e_wd; int e_ren; int e_ra;
        int e_pv; int e_pl; int e_err; int e_oob;
    } vec_t;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    vec_t vq[$];

    codemem_loader_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    codemem_loader_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int cs, input int bz, input int iv, input int il,
                         input int id, input int re, input int ra);
        bus.cfg_start   = cs[0];
        bus.cpu_busy    = bz[0];
        bus.in_valid    = iv[0];
        bus.in_last     = il[0];
        bus.in_data     = id[DW-1:0];
        bus.cpu_rd_en   = re[0];
        bus.cpu_rd_addr = ra[AW-1:0];
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("in_ready",    idx, 32'(bus.in_ready),    v.e_rdy);
        chk("mem_wr_en",   idx, 32'(bus.mem_wr_en),   v.e_wen);
        chk("mem_wr_addr", idx, 32'(bus.mem_wr_addr), v.e_wa);
        chk("mem_wr_data", idx, 32'(bus.mem_wr_data), v.e_wd);
        chk("mem_rd_en",   idx, 32'(bus.mem_rd_en),   v.e_ren);
        chk("mem_rd_addr", idx, 32'(bus.mem_rd_addr), v.e_ra);
        chk("prog_valid",  idx, 32'(bus.prog_valid),  v.e_pv);
        chk("prog_len",    idx, 32'(bus.prog_len),    v.e_pl);
        chk("load_err",    idx, 32'(bus.load_err),    v.e_err);
        chk("rd_oob",      idx, 32'(bus.rd_oob),      v.e_oob);
    endtask

    initial begin
        int writes;
        pass_cnt  = 0;
        total_cnt = 0;
        //            cs bz iv il data     re ra | rdy wen wa wdata    ren ra pv pl err oob
        vq.push_back('{0, 0, 0, 0, 0,       1, 5,   0, 0, 0, 0,       0, 0, 0, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 0,       0, 0,   0, 0, 0, 0,       0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 0, 1, 0, 'h1111,  0, 0,   1, 1, 0, 'h1111,  0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 0, 1, 0, 'h2222,  1, 7,   1, 1, 1, 'h2222,  0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 0, 0, 0, 'h9999,  0, 0,   1, 0, 0, 0,       0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 0, 1, 0, 'h3333,  0, 0,   1, 1, 2, 'h3333,  0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 0, 1, 1, 'h4444,  0, 0,   1, 1, 3, 'h4444,  0, 0, 0, 0, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0,       1, 3,   0, 0, 0, 0,       1, 3, 1, 4, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0,       1, 4,   0, 0, 0, 0,       1, 4, 1, 4, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 0,       0, 0, 1, 4, 0, 1});
        vq.push_back('{0, 0, 1, 1, 'h5555,  0, 0,   0, 0, 0, 0,       0, 0, 1, 4, 0, 0});
        vq.push_back('{1, 1, 0, 0, 0,       1, 0,   0, 0, 0, 0,       1, 0, 1, 4, 0, 0});
        vq.push_back('{0, 1, 0, 0, 0,       1, 1,   0, 0, 0, 0,       0, 0, 0, 4, 0, 0});
        vq.push_back('{1, 1, 0, 0, 0,       0, 0,   0, 0, 0, 0,       0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 1, 1, 0, 'h6666,  0, 0,   0, 0, 0, 0,       0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 1, 0, 0, 0,       0, 0,   0, 0, 0, 0,       0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 0,       0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 0, 1, 0, 'hB0B0,  0, 0,   1, 1, 0, 'hB0B0,  0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 0, 1, 0, 'hB1B1,  0, 0,   1, 1, 1, 'hB1B1,  0, 0, 0, 4, 0, 0});
        vq.push_back('{1, 0, 1, 0, 'hB2B2,  0, 0,   1, 0, 0, 0,       0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 0, 1, 0, 'hC0C0,  0, 0,   1, 1, 0, 'hC0C0,  0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 0, 1, 1, 'hC1C1,  0, 0,   1, 1, 1, 'hC1C1,  0, 0, 0, 4, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0,       1, 2,   0, 0, 0, 0,       1, 2, 1, 2, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 0,       0, 0, 1, 2, 0, 1});

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk_all(-1, '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vq[i]) begin
            drive(vq[i].cs, vq[i].bz, vq[i].iv, vq[i].il, vq[i].id, vq[i].re, vq[i].ra);
            #1;
            chk_all(i, vq[i]);
            tick();
        end

        // Overflow: DEPTH+1 words with no in_last
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        writes = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            drive(0, 0, 1, 0, 'h100 + i, 0, 0);
            #1;
            if (i < DEPTH) begin
                if (bus.mem_wr_en && (32'(bus.mem_wr_addr) == i) && (32'(bus.mem_wr_data) == 'h100 + i))
                    writes++;
                if (i == DEPTH - 1) chk("ovf_err_before", i, 32'(bus.load_err), 0);
            end else begin
                chk("ovf_extra_wen", i, 32'(bus.mem_wr_en), 0);
                chk("ovf_extra_rdy", i, 32'(bus.in_ready), 0);
            end
            tick();
        end
        chk("ovf_writes", 0, writes, DEPTH);
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("ovf_load_err", 0, 32'(bus.load_err), 1);
        chk("ovf_prog_valid", 0, 32'(bus.prog_valid), 0);
        chk("ovf_rd_blocked", 0, 32'(bus.mem_rd_en), 0);
        chk("ovf_prog_len", 0, 32'(bus.prog_len), 2);
        tick();
        chk("ovf_rd_oob", 0, 32'(bus.rd_oob), 0);

        // Reset in the middle of a load at wr_ptr=3
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rl_err_cleared", 0, 32'(bus.load_err), 0);
        chk("rl_in_ready", 0, 32'(bus.in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 'hA0 + i, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0, 'hDEAD, 0, 0);
        #1;
        chk("rl_wen_pre", 0, 32'(bus.mem_wr_en), 1);
        chk("rl_waddr_pre", 0, 32'(bus.mem_wr_addr), 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rl_rst_wen", 0, 32'(bus.mem_wr_en), 0);
        chk("rl_rst_waddr", 0, 32'(bus.mem_wr_addr), 0);
        chk("rl_rst_wdata", 0, 32'(bus.mem_wr_data), 0);
        chk("rl_rst_rdy", 0, 32'(bus.in_ready), 0);
        chk("rl_rst_pv", 0, 32'(bus.prog_valid), 0);
        chk("rl_rst_plen", 0, 32'(bus.prog_len), 0);
        chk("rl_rst_err", 0, 32'(bus.load_err), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 'hBEEF, 1, 0);
            #1;
            chk("rl_post_pv", i, 32'(bus.prog_valid), 0);
            chk("rl_post_wen", i, 32'(bus.mem_wr_en), 0);
            chk("rl_post_ren", i, 32'(bus.mem_rd_en), 0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
